// File: rtl/ahb_matrix_decoder_param.sv
// AHB matrix output-stage decoder: address-range port select, built-in default slave, data-phase response mux.
// Latency: sel_vec/active_dec are combinational; data-phase ready/resp/rdata follow the address phase by one HCLK.
// Backpressure: data_port and the default-slave OK-exit only advance on HREADYS; HREADYOUTS carries port or ERROR waits back.
module ahb_matrix_decoder_param #(
    parameter int                      NUM_PORTS = 2,
    parameter logic [22*NUM_PORTS-1:0] BASE      = {22'h100000, 22'h080000},
    parameter logic [22*NUM_PORTS-1:0] LIMIT     = {22'h13FFFF, 22'h08003F},
    parameter logic [NUM_PORTS-1:0]    PORT_EN   = {NUM_PORTS{1'b1}}
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      HREADYS,
    input  logic                      sel_dec,
    input  logic [21:0]               decode_addr_dec,
    input  logic [1:0]                trans_dec,
    input  logic [NUM_PORTS-1:0]      active_vec,
    input  logic [NUM_PORTS-1:0]      readyout_vec,
    input  logic [2*NUM_PORTS-1:0]    resp_vec,
    input  logic [32*NUM_PORTS-1:0]   rdata_vec,
    input  logic                      err_clr,
    output logic [NUM_PORTS-1:0]      sel_vec,
    output logic                      active_dec,
    output logic                      HREADYOUTS,
    output logic [1:0]                HRESPS,
    output logic [31:0]               HRDATAS,
    output logic [7:0]                err_cnt
);

    typedef enum logic [1:0] {
        DS_OK   = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    logic [NUM_PORTS:0] addr_port;
    logic [NUM_PORTS:0] data_port;
    logic               addr_hit;
    logic               ds_sel;
    logic               err_start;
    logic               err_entry;
    ds_state_t          ds_state;
    logic               ds_ready;
    logic [1:0]         ds_resp;

    // Address-phase target: sticky IDLE hold first, then lowest-index range match, else default slave
    always_comb begin
        addr_port = '0;
        addr_hit  = 1'b0;
        if (trans_dec == 2'b00) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (data_port[i]) begin
                    addr_port[i] = 1'b1;
                    addr_hit     = 1'b1;
                end
            end
        end
        if (!addr_hit) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!addr_hit && PORT_EN[i] &&
                    (decode_addr_dec >= BASE[22*i +: 22]) &&
                    (decode_addr_dec <= LIMIT[22*i +: 22])) begin
                    addr_port[i] = 1'b1;
                    addr_hit     = 1'b1;
                end
            end
        end
        if (!addr_hit) begin
            addr_port[NUM_PORTS] = 1'b1;
        end
    end

    // Per-port selects and the active flag of the current address-phase target
    always_comb begin
        sel_vec    = sel_dec ? addr_port[NUM_PORTS-1:0] : '0;
        active_dec = addr_port[NUM_PORTS];
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr_port[i] && active_vec[i]) begin
                active_dec = 1'b1;
            end
        end
    end

    assign ds_sel    = sel_dec & addr_port[NUM_PORTS];
    assign err_start = ds_sel & HREADYS & trans_dec[1];
    // ERR1 is the only state that cannot accept a new ERROR start
    assign err_entry = err_start & (ds_state != DS_ERR1);

    // Data-phase port register: captures the target when the previous transfer completes
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_port <= '0;
        end else if (HREADYS) begin
            data_port <= addr_port;
        end
    end

    // Default-slave two-cycle ERROR sequence with registered ready/response
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ds_state <= DS_OK;
            ds_ready <= 1'b1;
            ds_resp  <= 2'b00;
        end else begin
            case (ds_state)
                DS_ERR1: begin
                    ds_state <= DS_ERR2;
                    ds_ready <= 1'b1;
                    ds_resp  <= 2'b01;
                end
                DS_OK, DS_ERR2: begin
                    if (err_start) begin
                        ds_state <= DS_ERR1;
                        ds_ready <= 1'b0;
                        ds_resp  <= 2'b01;
                    end else begin
                        ds_state <= DS_OK;
                        ds_ready <= 1'b1;
                        ds_resp  <= 2'b00;
                    end
                end
                default: begin
                    ds_state <= DS_OK;
                    ds_ready <= 1'b1;
                    ds_resp  <= 2'b00;
                end
            endcase
        end
    end

    // Saturating count of ERROR sequences started; clear wins over a same-cycle increment
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_cnt <= 8'h00;
        end else if (err_clr) begin
            err_cnt <= 8'h00;
        end else if (err_entry && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end

    // Data-phase mux back to the input stage; an empty data phase returns a zero-wait OKAY
    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = 2'b00;
        HRDATAS    = 32'h0000_0000;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (data_port[i]) begin
                HREADYOUTS = readyout_vec[i];
                HRESPS     = resp_vec[2*i +: 2];
                HRDATAS    = rdata_vec[32*i +: 32];
            end
        end
        if (data_port[NUM_PORTS]) begin
            HREADYOUTS = ds_ready;
            HRESPS     = ds_resp;
            HRDATAS    = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_ahb_matrix_decoder_param.sv
// Bench for ahb_matrix_decoder_param: table-driven per-cycle vectors plus hand sequences.
// Inputs change 1 ns after HCLK rise; outputs are compared 4 ns after the rise.
// Three instances: default map, overlapping map, and overlapping map with port 0 disabled.
module tb_ahb_matrix_decoder_param;

    localparam logic [31:0] DA = 32'hAAAA_0000;
    localparam logic [31:0] DB = 32'hBBBB_1111;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HREADYS;
    logic        sel_dec;
    logic [21:0] decode_addr_dec;
    logic [1:0]  trans_dec;
    logic [1:0]  active_vec;
    logic [1:0]  readyout_vec;
    logic [3:0]  resp_vec;
    logic [63:0] rdata_vec;
    logic        err_clr;

    logic [1:0]  sel_vec;
    logic        active_dec;
    logic        HREADYOUTS;
    logic [1:0]  HRESPS;
    logic [31:0] HRDATAS;
    logic [7:0]  err_cnt;

    logic [1:0]  ov_sel_vec, ds_sel_vec;
    logic        ov_active, ds_active;
    logic        ov_ready, ds_ready;
    logic [1:0]  ov_resp, ds_resp;
    logic [31:0] ov_rdata, ds_rdata;
    logic [7:0]  ov_cnt, ds_cnt;

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    ahb_matrix_decoder_param dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HREADYS(HREADYS), .sel_dec(sel_dec),
        .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec), .active_vec(active_vec),
        .readyout_vec(readyout_vec), .resp_vec(resp_vec), .rdata_vec(rdata_vec),
        .err_clr(err_clr), .sel_vec(sel_vec), .active_dec(active_dec),
        .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .HRDATAS(HRDATAS), .err_cnt(err_cnt)
    );

    ahb_matrix_decoder_param #(
        .NUM_PORTS(2),
        .BASE({22'h080000, 22'h080000}),
        .LIMIT({22'h08FFFF, 22'h08FFFF})
    ) dut_ov (
        .HCLK(HCLK), .HRESETn(HRESETn), .HREADYS(HREADYS), .sel_dec(sel_dec),
        .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec), .active_vec(active_vec),
        .readyout_vec(readyout_vec), .resp_vec(resp_vec), .rdata_vec(rdata_vec),
        .err_clr(err_clr), .sel_vec(ov_sel_vec), .active_dec(ov_active),
        .HREADYOUTS(ov_ready), .HRESPS(ov_resp), .HRDATAS(ov_rdata), .err_cnt(ov_cnt)
    );

    ahb_matrix_decoder_param #(
        .NUM_PORTS(2),
        .BASE({22'h080000, 22'h080000}),
        .LIMIT({22'h08FFFF, 22'h08FFFF}),
        .PORT_EN(2'b10)
    ) dut_dis (
        .HCLK(HCLK), .HRESETn(HRESETn), .HREADYS(HREADYS), .sel_dec(sel_dec),
        .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec), .active_vec(active_vec),
        .readyout_vec(readyout_vec), .resp_vec(resp_vec), .rdata_vec(rdata_vec),
        .err_clr(err_clr), .sel_vec(ds_sel_vec), .active_dec(ds_active),
        .HREADYOUTS(ds_ready), .HRESPS(ds_resp), .HRDATAS(ds_rdata), .err_cnt(ds_cnt)
    );

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [21:0] addr;
        logic        rdy;
        logic        clr;
        logic [1:0]  e_sel;
        logic        e_act;
        logic        e_ready;
        logic [1:0]  e_resp;
        logic [31:0] e_data;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [1:0] t, input logic [21:0] a,
                         input logic r, input logic c);
        @(posedge HCLK);
        #1;
        sel_dec         = s;
        trans_dec       = t;
        decode_addr_dec = a;
        HREADYS         = r;
        err_clr         = c;
        #3;
    endtask

    task automatic chk_data(input string tag, input logic rdy, input logic [1:0] rsp,
                            input logic [7:0] cnt);
        chk({tag, ".ready"}, {31'd0, HREADYOUTS}, {31'd0, rdy});
        chk({tag, ".resp"}, {30'd0, HRESPS}, {30'd0, rsp});
        chk({tag, ".cnt"}, {24'd0, err_cnt}, {24'd0, cnt});
    endtask

    initial begin
        // Port 0: inactive, ready, OKAY, data A. Port 1: active, waiting, resp 10, data B.
        active_vec   = 2'b10;
        readyout_vec = 2'b01;
        resp_vec     = 4'b1000;
        rdata_vec    = {DB, DA};

        //               sel trans  addr        rdy clr  e_sel  act rdy resp   data cnt
        vecs[0]  = '{1'b0, 2'b00, 22'h000000, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 32'h0, 8'd0};
        vecs[1]  = '{1'b1, 2'b10, 22'h080010, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 32'h0, 8'd0};
        vecs[2]  = '{1'b1, 2'b10, 22'h13FFFF, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, DA,    8'd0};
        vecs[3]  = '{1'b1, 2'b10, 22'h140000, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b10, DB,    8'd0};
        vecs[4]  = '{1'b1, 2'b10, 22'h080020, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b01, 32'h0, 8'd1};
        vecs[5]  = '{1'b1, 2'b10, 22'h080020, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 2'b01, 32'h0, 8'd1};
        vecs[6]  = '{1'b1, 2'b10, 22'h100000, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, DA,    8'd1};
        vecs[7]  = '{1'b1, 2'b00, 22'h000000, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 2'b10, DB,    8'd1};
        vecs[8]  = '{1'b0, 2'b00, 22'h000000, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b10, DB,    8'd1};
        vecs[9]  = '{1'b1, 2'b10, 22'h3FFFFF, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b10, DB,    8'd1};
        vecs[10] = '{1'b1, 2'b00, 22'h3FFFFF, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b01, 32'h0, 8'd2};
        vecs[11] = '{1'b1, 2'b00, 22'h3FFFFF, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 2'b01, 32'h0, 8'd2};
        vecs[12] = '{1'b1, 2'b01, 22'h3FFFFF, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 32'h0, 8'd2};
        vecs[13] = '{1'b1, 2'b10, 22'h3FFFFF, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 32'h0, 8'd2};
        vecs[14] = '{1'b1, 2'b11, 22'h3FFFFF, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b01, 32'h0, 8'd3};
        vecs[15] = '{1'b1, 2'b11, 22'h3FFFFF, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 2'b01, 32'h0, 8'd3};
        vecs[16] = '{1'b0, 2'b00, 22'h000000, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b01, 32'h0, 8'd4};
        vecs[17] = '{1'b0, 2'b00, 22'h000000, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 2'b01, 32'h0, 8'd4};
        vecs[18] = '{1'b0, 2'b00, 22'h080000, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 32'h0, 8'd0};

        // Reset: hold HREADYS low so data_port stays empty until the table starts
        HRESETn         = 1'b0;
        HREADYS         = 1'b0;
        sel_dec         = 1'b0;
        trans_dec       = 2'b00;
        decode_addr_dec = 22'h000000;
        err_clr         = 1'b0;
        #2;
        chk_data("reset", 1'b1, 2'b00, 8'h00);
        chk("reset.data", HRDATAS, 32'h0);
        #10;
        HRESETn = 1'b1;

        for (int v = 0; v < 19; v++) begin
            drive(vecs[v].sel, vecs[v].trans, vecs[v].addr, vecs[v].rdy, vecs[v].clr);
            chk($sformatf("v%0d.sel", v), {30'd0, sel_vec}, {30'd0, vecs[v].e_sel});
            chk($sformatf("v%0d.active", v), {31'd0, active_dec}, {31'd0, vecs[v].e_act});
            chk_data($sformatf("v%0d", v), vecs[v].e_ready, vecs[v].e_resp, vecs[v].e_cnt);
            chk($sformatf("v%0d.data", v), HRDATAS, vecs[v].e_data);
        end

        // 256 back-to-back unmapped NONSEQs: each enters ERR1 from OK or ERR2
        for (int k = 0; k < 256; k++) begin
            drive(1'b1, 2'b10, 22'h3FFFFF, 1'b1, 1'b0);
            drive(1'b1, 2'b10, 22'h3FFFFF, 1'b0, 1'b0);
            if (k == 0)   chk_data("sat.first", 1'b0, 2'b01, 8'd1);
            if (k == 253) chk("sat.fe", {24'd0, err_cnt}, 32'hFE);
            if (k == 254) chk("sat.ff", {24'd0, err_cnt}, 32'hFF);
            if (k == 255) chk("sat.hold", {24'd0, err_cnt}, 32'hFF);
        end

        // Clear coincident with a new ERR1 entry from ERR2
        drive(1'b1, 2'b10, 22'h3FFFFF, 1'b1, 1'b1);
        chk_data("clr.err2", 1'b1, 2'b01, 8'hFF);
        drive(1'b1, 2'b10, 22'h3FFFFF, 1'b0, 1'b0);
        chk_data("clr.err1", 1'b0, 2'b01, 8'h00);
        drive(1'b1, 2'b10, 22'h3FFFFF, 1'b1, 1'b0);
        drive(1'b1, 2'b10, 22'h3FFFFF, 1'b0, 1'b0);
        chk_data("pre_rst.err1", 1'b0, 2'b01, 8'h01);

        // Asynchronous reset in the middle of ERR1
        HRESETn = 1'b0;
        #1;
        chk_data("rst.err1", 1'b1, 2'b00, 8'h00);
        chk("rst.data", HRDATAS, 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Overlapping map: lowest enabled index wins
        drive(1'b1, 2'b10, 22'h080100, 1'b1, 1'b0);
        chk("ovl.default_map", {30'd0, sel_vec}, 32'h0);
        chk("ovl.lowest", {30'd0, ov_sel_vec}, 32'h1);
        chk("ovl.disabled", {30'd0, ds_sel_vec}, 32'h2);
        chk("ovl.active", {31'd0, ds_active}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
